// File: rtl/gsim_pkg.sv
// Shared types and constants for the matrix-memory read responder.
package gsim_pkg;

  localparam int unsigned ROW_W   = 256;
  localparam int unsigned SRAM_W  = 64;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned BEATS   = 4;
  localparam int unsigned BEAT_W  = $clog2(BEATS);
  localparam int unsigned SADDR_W = ADDR_W + BEAT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_RESP
  } state_t;

endpackage

// File: rtl/gsim_rd_lat_pipe.sv
// SRAM_LAT-stage delay line carrying {valid, beat} alongside SRAM read latency.
module gsim_rd_lat_pipe
  import gsim_pkg::*;
#(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vld,
  input  logic [BEAT_W-1:0] i_beat,
  output logic              o_vld,
  output logic [BEAT_W-1:0] o_beat
);

  logic [SRAM_LAT-1:0]             r_vld;
  logic [SRAM_LAT-1:0][BEAT_W-1:0] r_beat;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld  <= '0;
      r_beat <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_beat[0] <= i_beat;
      for (int unsigned i = 1; i < SRAM_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_beat[i] <= r_beat[i-1];
      end
    end
  end

  assign o_vld  = r_vld[SRAM_LAT-1];
  assign o_beat = r_beat[SRAM_LAT-1];

endmodule

// File: rtl/gsim_mat_mem_if.sv
// Matrix-memory read responder: fetches a 256-bit row as four 64-bit SRAM beats
// and returns it with a one-cycle valid pulse.
module gsim_mat_mem_if
  import gsim_pkg::*;
#(
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_mem_rreq,
  input  logic [9:0]   i_mem_addr,
  output logic         o_mem_rrdy,
  output logic [255:0] o_mem_dout,
  output logic         o_mem_dout_vld,
  output logic         o_sram_ren,
  output logic [11:0]  o_sram_addr,
  input  logic [63:0]  i_sram_q
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_rrdy_nxt;
  logic                w_ren_nxt;
  logic                w_vld_nxt;
  logic                w_load_dout;
  logic [11:0]         w_addr_nxt;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    w_row_nxt;
  logic                w_cap_vld;
  logic [BEAT_W-1:0]   w_cap_beat;
  logic                w_last_cap;
  logic                w_accept;

  gsim_rd_lat_pipe #(
    .SRAM_LAT(SRAM_LAT)
  ) u_lat_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (o_sram_ren),
    .i_beat  (o_sram_addr[BEAT_W-1:0]),
    .o_vld   (w_cap_vld),
    .o_beat  (w_cap_beat)
  );

  assign w_accept   = i_mem_rreq & o_mem_rrdy;
  assign w_last_cap = w_cap_vld && (w_cap_beat == BEAT_W'(BEATS - 1));

  // Beats land in a private row buffer; o_mem_dout only loads the completed row,
  // including the final beat arriving on the same edge.
  always_comb begin
    w_row_nxt = r_row;
    if (w_cap_vld) begin
      w_row_nxt[w_cap_beat*SRAM_W +: SRAM_W] = i_sram_q;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rrdy_nxt  = 1'b0;
    w_ren_nxt   = 1'b0;
    w_vld_nxt   = 1'b0;
    w_load_dout = 1'b0;
    w_addr_nxt  = o_sram_addr;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
          w_ren_nxt   = 1'b1;
          w_addr_nxt  = {i_mem_addr, {BEAT_W{1'b0}}};
        end else begin
          w_state_nxt = S_IDLE;
          w_rrdy_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (o_sram_addr[BEAT_W-1:0] == BEAT_W'(BEATS - 1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_ren_nxt  = 1'b1;
          w_addr_nxt = o_sram_addr + 12'd1;
        end
      end
      S_DRAIN: begin
        if (w_last_cap) begin
          w_state_nxt = S_RESP;
          w_rrdy_nxt  = 1'b1;
          w_vld_nxt   = 1'b1;
          w_load_dout = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_row          <= '0;
      o_mem_rrdy     <= 1'b0;
      o_mem_dout     <= '0;
      o_mem_dout_vld <= 1'b0;
      o_sram_ren     <= 1'b0;
      o_sram_addr    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_row          <= w_row_nxt;
      o_mem_rrdy     <= w_rrdy_nxt;
      o_mem_dout_vld <= w_vld_nxt;
      o_sram_ren     <= w_ren_nxt;
      o_sram_addr    <= w_addr_nxt;
      if (w_load_dout) begin
        o_mem_dout <= w_row_nxt;
      end
    end
  end

endmodule

// File: doc/gsim_mat_mem_if.md
Name: gsim_mat_mem_if

Overview:
- Responder end of the solver's matrix-memory read protocol.
- Accepts a 10-bit row address from the solver and fetches the 256-bit row (16 x 16-bit coefficients, or b/reciprocal row) from a 64-bit-wide single-port SRAM, four beats per row.
- Returns the assembled row with a one-cycle valid pulse.
- Sits between the solver core and the matrix SRAM macro.

Parameters:
SRAM_LAT, 1, SRAM read latency in cycles from o_sram_ren to valid i_sram_q (legal 1..3)
BEATS, 4, 64-bit SRAM words per 256-bit row (fixed; not for override)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_mem_rreq  in  1  read request from solver; may be held high
i_mem_addr  in  10  row address, sampled on acceptance
o_mem_rrdy  out  1  responder can accept a request this cycle
o_mem_dout  out  256  assembled row; beat k at bits [64k+63:64k]
o_mem_dout_vld  out  1  one-cycle pulse, o_mem_dout valid
o_sram_ren  out  1  SRAM read enable
o_sram_addr  out  12  SRAM word address = {row_addr, beat[1:0]}
i_sram_q  in  64  SRAM read data

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, asynchronous and active-high. All state and outputs clear immediately on assertion.
- Reset values: o_mem_rrdy=0, o_mem_dout=0, o_mem_dout_vld=0, o_sram_ren=0, o_sram_addr=0, FSM=S_IDLE, counters=0.
- Registered outputs only. o_mem_rrdy is 0 in the reset cycle and rises 1 in the first cycle after i_reset deasserts.
- Acceptance: a request is accepted in a cycle where i_mem_rreq=1 and o_mem_rrdy=1. i_mem_addr is latched that cycle. rreq while rrdy=0 is ignored, with no queueing.
- FSM states:
  - S_IDLE: rrdy=1. On accept go to S_ISSUE; rrdy falls next cycle.
  - S_ISSUE: exactly BEATS cycles. ren=1 and addr={row,beat} with beat 0,1,2,3 in consecutive cycles. Then go to S_DRAIN.
  - S_DRAIN: ren=0. Wait until all BEATS returns are captured, then go to S_RESP.
  - S_RESP: one cycle. dout_vld=1 and rrdy=1. An accept in this cycle goes directly to S_ISSUE (back-to-back); otherwise go to S_IDLE.
- Return capture:
  - A delay line of SRAM_LAT stages carries {valid, beat}.
  - When the stage output is valid, i_sram_q is written into lane beat of the row buffer at that edge.
  - Lanes not yet rewritten keep their old contents, but all four are rewritten before vld.
- Latency, with accept at cycle T:
  - ren cycles T+1..T+4.
  - Last beat captured at the end of cycle T+4+SRAM_LAT.
  - vld cycle T+5+SRAM_LAT; for SRAM_LAT=1 that is T+6.
  - Throughput: one row per 5+SRAM_LAT cycles when back-to-back.
- o_mem_dout holds the last row until the next vld; it does not change in the vld cycle's following cycles until a new row completes.
- Address range: all 1024 row addresses are legal. SRAM address 12'hFFF is reached by row 1023 beat 3; there is no wrap.
- Reset mid-operation, in any state: in-flight beats are discarded, the delay line is cleared, and no vld is issued for the aborted request.
- Simultaneous events: in S_RESP, accept and vld in the same cycle are legal. The new request's ren starts the next cycle and does not corrupt the current dout.

Decomposition:
- Shared package gsim_pkg:
  - state encoding: S_IDLE, S_ISSUE, S_DRAIN, S_RESP
  - ROW_W=256, SRAM_W=64, ADDR_W=10
  - BEATS, beat index width
- One natural sub-module, gsim_rd_lat_pipe: parameterised SRAM_LAT-stage shift register of {valid, beat[1:0]}, async reset to all-zero.

Test Plan:
- Reset release -> rrdy=0 during reset, rrdy=1 next cycle; dout=0, vld=0, ren=0.
- Single read, addr=10'd17, SRAM word n preloaded with n:
  - sram_addr 68,69,70,71 on four consecutive ren cycles.
  - vld exactly 6 cycles after accept.
  - dout={64'd71,64'd70,64'd69,64'd68}.
- rreq held high for 3 rows (0,1,2):
  - accepts only in IDLE/RESP cycles.
  - vld pulses spaced 6 cycles apart.
  - rows returned in order with correct data.
  - no extra accept while rrdy=0.
- SRAM_LAT=3, addr=10'd1023 -> sram_addr 4092..4095; vld at T+8; no address wrap.
- Reset asserted in S_DRAIN after 2 beats captured -> immediate clear; no vld afterwards; next request addr=5 returns a clean row from words 20..23.
- rreq pulsed while rrdy=0, during S_ISSUE -> ignored; ren count stays 4 per accepted request.
